edge_bit_packer: RTL and testbench
==================================

Name: edge_bit_packer

Overview:
Sits directly downstream of the hysteresis stage and consumes its edge_out/edge_out_valid stream: 8-bit pixels, 0 = no edge, non-zero = edge.
- Reduces each pixel to 1 bit and packs bits LSB-first into fixed-width words.
- Tracks raster position in the frame and tags words with start-of-frame and end-of-line flags.
- Buffers words in a small FIFO behind a valid/ready handshake toward the frame-store/DMA writer.
- The upstream pipeline has no backpressure, so FIFO overflow is detected and flagged rather than stalled.

Parameters:
IMG_WIDTH, 512, pixels per row (>=1)
IMG_HEIGHT, 512, rows per frame (>=1)
WORD_W, 32, packed word width in bits (power of 2, >=8)
FIFO_DEPTH, 4, output FIFO entries (power of 2, >=2)

Ports:
clk  in  1  clock, all logic on rising edge
rstN  in  1  asynchronous reset, active-high (1 = reset asserted)
edge_in  in  8  pixel from hysteresis stage
edge_in_valid  in  1  edge_in valid this cycle; no ready returned
word_out  out  WORD_W  packed edge bits; bit k = pixel column (word_base + k)
word_out_valid  out  1  FIFO non-empty
word_out_ready  in  1  sink accepts word_out this cycle
word_sof  out  1  word_out is the first word of a frame
word_eol  out  1  word_out is the last word of a row
frame_done  out  1  one-cycle pulse when the last word of a frame is popped
overflow  out  1  sticky; a completed word was dropped because the FIFO was full

Behaviour:
- Reset (async assert, sync release): col=0, row=0, bit accumulator=0, FIFO empty. All outputs 0: word_out, word_out_valid, word_sof, word_eol, frame_done, overflow.
- Each cycle with edge_in_valid=1:
  - Pixel bit = (edge_in != 0).
  - Bit is written to accumulator position col mod WORD_W.
  - col increments; at col == IMG_WIDTH-1, col wraps to 0 and row increments.
  - At row == IMG_HEIGHT-1 with col == IMG_WIDTH-1, row wraps to 0 and the next pixel starts a new frame.
- Word completion occurs on an accepted pixel when (col mod WORD_W) == WORD_W-1 or col == IMG_WIDTH-1.
  - Partial words at row end are zero-padded in the upper bits.
  - Words never span rows.
- Completed word push:
  - Pushed into FIFO on the same clock edge as the completing pixel.
  - Sideband pushed with it: sof = (row==0 && word is first in row); eol = (col==IMG_WIDTH-1); last-of-frame flag (internal).
  - The accumulator clears for the next word in the same edge, with no gap cycle.
- Latency: word_out_valid rises in the cycle after the clock edge that accepted the completing pixel, provided the FIFO was empty.
- FIFO head drives word_out/word_sof/word_eol directly. Pop occurs when word_out_valid && word_out_ready. word_out is stable while valid && !ready.
- Simultaneous push and pop when full: push succeeds and occupancy stays full.
- Push when full without pop: word is dropped, overflow set to 1 and held until reset. Position counters still advance so subsequent words stay correctly aligned.
- frame_done: registered pulse in the cycle after popping a word tagged last-of-frame.
- edge_in_valid low: counters and accumulator hold, with no timeout flush.
- Reset mid-frame: partial word discarded, FIFO flushed, next valid pixel treated as row 0, col 0.

Optional Feature:
Macro EDGE_BIT_PACKER_COUNT_EN.
- Defined: adds output port edge_count [$clog2(IMG_WIDTH*IMG_HEIGHT+1)-1:0], reset 0.
  - An internal counter adds each accepted pixel's bit.
  - On the last pixel of a frame, edge_count is loaded with the frame total, including that pixel, and the internal counter restarts at 0.
  - edge_count holds until the next frame completes. Dropped (overflowed) words are still counted.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Row of alternating pixels 0xFF,0x00 (512 px), word_out_ready=1, WORD_W=32 -> 16 words each 32'h55555555; first has word_sof=1; 16th has word_eol=1; word_out_valid 1 cycle after each 32nd pixel.
- IMG_WIDTH=40, all pixels 0x01 -> per row word0=32'hFFFFFFFF (eol=0), word1=32'h000000FF (eol=1, upper bits zero).
- word_out_ready=0 for full 512x512 frame of 0xFF, FIFO_DEPTH=4 -> first 4 words retained; overflow rises on 5th completed word (pixel 160) and stays 1; after ready=1, exactly 4 words pop, first with sof=1.
- Full frame with ready=1 -> 8192 words, frame_done pulses exactly once, 1 cycle after last pop. Next frame's first word has sof=1.
- Assert rstN=1 mid-row (col=100, row=3), release, stream new frame -> all outputs 0 during reset; overflow cleared; first post-reset word has sof=1 and contains only post-reset pixels.
- With EDGE_BIT_PACKER_COUNT_EN, frame with 1000 non-zero pixels -> edge_count=1000 one cycle after last pixel; next frame of all zeros -> edge_count=0.

Source files
------------

// File: rtl/edge_bit_packer_if.sv
// Pixel-in / packed-word-out bundle for edge_bit_packer.
// master = packer side, slave = the upstream source plus the downstream word sink.
interface edge_bit_packer_if #(
   parameter int WORD_W = 32
);
   logic [7:0]        edge_in;
   logic              edge_in_valid;
   logic [WORD_W-1:0] word_out;
   logic              word_out_valid;
   logic              word_out_ready;
   logic              word_sof;
   logic              word_eol;
   logic              frame_done;
   logic              overflow;

   modport master (
      input  edge_in, edge_in_valid, word_out_ready,
      output word_out, word_out_valid, word_sof, word_eol, frame_done, overflow
   );

   modport slave (
      output edge_in, edge_in_valid, word_out_ready,
      input  word_out, word_out_valid, word_sof, word_eol, frame_done, overflow
   );
endinterface

// File: rtl/edge_bit_packer.sv
// Packs 1-bit edge flags LSB-first into WORD_W words with SOF/EOL tags behind a small FIFO.
// Optional per-frame edge counter output when EDGE_BIT_PACKER_COUNT_EN is defined.
module edge_bit_packer #(
   parameter int IMG_WIDTH  = 512,
   parameter int IMG_HEIGHT = 512,
   parameter int WORD_W     = 32,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                clk,
   input  logic                rstN,
   edge_bit_packer_if.master   bus
`ifdef EDGE_BIT_PACKER_COUNT_EN
   ,
   output logic [$clog2(IMG_WIDTH*IMG_HEIGHT+1)-1:0] edge_count
`endif
);

   localparam int CW   = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
   localparam int RW   = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
   localparam int BW   = $clog2(WORD_W);
   localparam int AW   = $clog2(FIFO_DEPTH);
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

   logic [CW-1:0]     col_q, col_d;
   logic [RW-1:0]     row_q, row_d;
   logic [WORD_W-1:0] acc_q, acc_d;

   logic [CW+BW-1:0]  col_ext;
   logic [BW-1:0]     bit_idx;
   logic              px_bit, col_end, row_end, word_done, push;
   logic [WORD_W-1:0] word_new;
   logic              sof_new, eol_new, last_new;

   always_comb begin
      col_ext   = {{BW{1'b0}}, col_q};
      bit_idx   = col_ext[BW-1:0];
      px_bit    = |bus.edge_in;
      col_end   = (col_q == COL_LAST);
      row_end   = (row_q == ROW_LAST);
      word_new  = acc_q | (WORD_W'(px_bit) << bit_idx);
      word_done = (bit_idx == '1) || col_end;
      // word base is column 0 exactly when the column has no bits above the word index
      sof_new   = (row_q == '0) && (col_ext[CW+BW-1:BW] == '0);
      eol_new   = col_end;
      last_new  = col_end && row_end;
      push      = bus.edge_in_valid && word_done;

      col_d = col_q;
      row_d = row_q;
      acc_d = acc_q;
      if (bus.edge_in_valid) begin
         acc_d = word_done ? '0 : word_new;
         if (col_end) begin
            col_d = '0;
            row_d = row_end ? '0 : row_q + 1'b1;
         end else begin
            col_d = col_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rstN) begin
      if (rstN) begin
         col_q <= '0;
         row_q <= '0;
         acc_q <= '0;
      end else begin
         col_q <= col_d;
         row_q <= row_d;
         acc_q <= acc_d;
      end
   end

   logic [WORD_W-1:0] mem_word [FIFO_DEPTH];
   logic              mem_sof  [FIFO_DEPTH];
   logic              mem_eol  [FIFO_DEPTH];
   logic              mem_last [FIFO_DEPTH];

   logic [AW:0] wr_q, wr_d, rd_q, rd_d;
   logic        empty, full, pop, push_ok;
   logic        overflow_q, overflow_d, frame_done_q, frame_done_d;

   always_comb begin
      empty   = (wr_q == rd_q);
      full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
      pop     = !empty && bus.word_out_ready;
      // a pop in the same edge frees the slot, so a push into a full FIFO still lands
      push_ok = push && (!full || pop);

      wr_d         = push_ok ? wr_q + 1'b1 : wr_q;
      rd_d         = pop     ? rd_q + 1'b1 : rd_q;
      overflow_d   = overflow_q | (push && !push_ok);
      frame_done_d = pop && mem_last[rd_q[AW-1:0]];

      bus.word_out_valid = !empty;
      bus.word_out       = empty ? '0   : mem_word[rd_q[AW-1:0]];
      bus.word_sof       = empty ? 1'b0 : mem_sof[rd_q[AW-1:0]];
      bus.word_eol       = empty ? 1'b0 : mem_eol[rd_q[AW-1:0]];
      bus.frame_done     = frame_done_q;
      bus.overflow       = overflow_q;
   end

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_word[wr_q[AW-1:0]] <= word_new;
         mem_sof [wr_q[AW-1:0]] <= sof_new;
         mem_eol [wr_q[AW-1:0]] <= eol_new;
         mem_last[wr_q[AW-1:0]] <= last_new;
      end
   end

   always_ff @(posedge clk or posedge rstN) begin
      if (rstN) begin
         wr_q         <= '0;
         rd_q         <= '0;
         overflow_q   <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         wr_q         <= wr_d;
         rd_q         <= rd_d;
         overflow_q   <= overflow_d;
         frame_done_q <= frame_done_d;
      end
   end

`ifdef EDGE_BIT_PACKER_COUNT_EN
   localparam int CNTW = $clog2(IMG_WIDTH*IMG_HEIGHT+1);

   logic [CNTW-1:0] cnt_q, cnt_d, edge_count_q, edge_count_d;

   always_comb begin
      cnt_d        = cnt_q;
      edge_count_d = edge_count_q;
      if (bus.edge_in_valid) begin
         if (last_new) begin
            edge_count_d = cnt_q + CNTW'(px_bit);
            cnt_d        = '0;
         end else begin
            cnt_d = cnt_q + CNTW'(px_bit);
         end
      end
   end

   always_ff @(posedge clk or posedge rstN) begin
      if (rstN) begin
         cnt_q        <= '0;
         edge_count_q <= '0;
      end else begin
         cnt_q        <= cnt_d;
         edge_count_q <= edge_count_d;
      end
   end

   assign edge_count = edge_count_q;
`endif

endmodule

// File: tb/tb_edge_bit_packer.sv
// Directed bench for edge_bit_packer on a 40x3 image with 32-bit words and a 4-entry FIFO.
module tb_edge_bit_packer;
   localparam int W  = 40;
   localparam int H  = 3;
   localparam int WW = 32;
   localparam int D  = 4;

   logic clk = 1'b0;
   logic rstN;
   always #5 clk = ~clk;

   edge_bit_packer_if #(.WORD_W(WW)) bus ();

`ifdef EDGE_BIT_PACKER_COUNT_EN
   logic [$clog2(W*H+1)-1:0] edge_count;
`endif

   edge_bit_packer #(
      .IMG_WIDTH  (W),
      .IMG_HEIGHT (H),
      .WORD_W     (WW),
      .FIFO_DEPTH (D)
   ) dut (
      .clk  (clk),
      .rstN (rstN),
      .bus  (bus)
`ifdef EDGE_BIT_PACKER_COUNT_EN
      ,
      .edge_count (edge_count)
`endif
   );

   typedef struct packed {
      logic [WW-1:0] w;
      logic          sof;
      logic          eol;
   } rec_t;

   rec_t q[$];
   int   fd_cnt = 0;
   int   checks = 0;
   int   failures = 0;

   // Words are recorded where the handshake completes on the following rising edge.
   always @(negedge clk) begin
      if (bus.word_out_valid && bus.word_out_ready)
         q.push_back('{w: bus.word_out, sof: bus.word_sof, eol: bus.word_eol});
      if (bus.frame_done)
         fd_cnt++;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic px(input logic [7:0] v);
      bus.edge_in       = v;
      bus.edge_in_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.edge_in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic logic [63:0] recv(input int idx);
      rec_t r;
      r = (idx < q.size()) ? q[idx] : '0;
      return 64'(r);
   endfunction

   function automatic logic [63:0] mk(input logic [WW-1:0] w, input logic s, input logic e);
      rec_t r;
      r = '{w: w, sof: s, eol: e};
      return 64'(r);
   endfunction

   int base;
   int fd_base;

   initial begin
      rstN               = 1'b1;
      bus.edge_in        = '0;
      bus.edge_in_valid  = 1'b0;
      bus.word_out_ready = 1'b0;
      idle(2);
      chk("rst_valid", 64'(bus.word_out_valid), 64'd0);
      chk("rst_word",  64'(bus.word_out),       64'd0);
      chk("rst_sof",   64'(bus.word_sof),       64'd0);
      chk("rst_eol",   64'(bus.word_eol),       64'd0);
      chk("rst_fd",    64'(bus.frame_done),     64'd0);
      chk("rst_ovf",   64'(bus.overflow),       64'd0);
`ifdef EDGE_BIT_PACKER_COUNT_EN
      chk("rst_cnt",   64'(edge_count),         64'd0);
`endif
      rstN = 1'b0;
      idle(1);

      // Frame A: alternating FF/00, sink always ready
      bus.word_out_ready = 1'b1;
      base = q.size(); fd_base = fd_cnt;
      for (int i = 0; i < W*H; i++) begin
         px((i % 2 == 0) ? 8'hFF : 8'h00);
         if (i == 30) chk("A_lat_before", 64'(bus.word_out_valid), 64'd0);
         if (i == 31) begin
            chk("A_lat_valid", 64'(bus.word_out_valid), 64'd1);
            chk("A_lat_word",  64'(bus.word_out),       64'h5555_5555);
            chk("A_lat_sof",   64'(bus.word_sof),       64'd1);
         end
      end
      chk("A_fd_0", 64'(bus.frame_done), 64'd0);
`ifdef EDGE_BIT_PACKER_COUNT_EN
      chk("A_cnt", 64'(edge_count), 64'd60);
`endif
      idle(1);
      chk("A_fd_1",    64'(bus.frame_done),     64'd1);
      chk("A_empty",   64'(bus.word_out_valid), 64'd0);
      idle(1);
      chk("A_fd_2", 64'(bus.frame_done), 64'd0);
      chk("A_nwords", 64'(q.size() - base), 64'd6);
      for (int r = 0; r < H; r++) begin
         chk("A_w0", recv(base + 2*r),     mk(32'h5555_5555, (r == 0), 1'b0));
         chk("A_w1", recv(base + 2*r + 1), mk(32'h0000_0055, 1'b0, 1'b1));
      end
      chk("A_fd_count", 64'(fd_cnt - fd_base), 64'd1);

      // Frame B: all 0x01 with idle gaps on edge_in_valid
      base = q.size(); fd_base = fd_cnt;
      for (int i = 0; i < W*H; i++) begin
         px(8'h01);
         if (i == W*H-1) begin
`ifdef EDGE_BIT_PACKER_COUNT_EN
            chk("B_cnt", 64'(edge_count), 64'd120);
`endif
         end
         if (i % 7 == 6) idle(2);
      end
      idle(4);
      chk("B_nwords", 64'(q.size() - base), 64'd6);
      for (int r = 0; r < H; r++) begin
         chk("B_w0", recv(base + 2*r),     mk(32'hFFFF_FFFF, (r == 0), 1'b0));
         chk("B_w1", recv(base + 2*r + 1), mk(32'h0000_00FF, 1'b0, 1'b1));
      end
      chk("B_fd_count", 64'(fd_cnt - fd_base), 64'd1);

      // Frame C: sink stalled, FIFO fills after 4 words and later words are dropped
      bus.word_out_ready = 1'b0;
      base = q.size(); fd_base = fd_cnt;
      for (int i = 0; i < W*H; i++) begin
         px(8'hFF);
         if (i == 79) begin
            chk("C_ovf_pre", 64'(bus.overflow),       64'd0);
            chk("C_valid",   64'(bus.word_out_valid), 64'd1);
         end
         if (i == 111) chk("C_ovf_rise", 64'(bus.overflow), 64'd1);
      end
      chk("C_ovf_hold",  64'(bus.overflow), 64'd1);
      chk("C_head_word", 64'(bus.word_out), 64'hFFFF_FFFF);
      chk("C_head_sof",  64'(bus.word_sof), 64'd1);
`ifdef EDGE_BIT_PACKER_COUNT_EN
      chk("C_cnt", 64'(edge_count), 64'd120);
`endif
      bus.word_out_ready = 1'b1;
      idle(8);
      chk("C_nwords", 64'(q.size() - base), 64'd4);
      chk("C_w0", recv(base),     mk(32'hFFFF_FFFF, 1'b1, 1'b0));
      chk("C_w1", recv(base + 1), mk(32'h0000_00FF, 1'b0, 1'b1));
      chk("C_w2", recv(base + 2), mk(32'hFFFF_FFFF, 1'b0, 1'b0));
      chk("C_w3", recv(base + 3), mk(32'h0000_00FF, 1'b0, 1'b1));
      chk("C_fd_none",  64'(fd_cnt - fd_base),  64'd0);
      chk("C_ovf_after", 64'(bus.overflow),     64'd1);
      chk("C_drained",  64'(bus.word_out_valid), 64'd0);

      // Reset in the middle of row 1 with words queued
      bus.word_out_ready = 1'b0;
      for (int i = 0; i < 50; i++) px(8'hFF);
      chk("D_pre_valid", 64'(bus.word_out_valid), 64'd1);
      rstN = 1'b1;
      #1;
      chk("D_rst_valid", 64'(bus.word_out_valid), 64'd0);
      chk("D_rst_word",  64'(bus.word_out),       64'd0);
      chk("D_rst_ovf",   64'(bus.overflow),       64'd0);
      chk("D_rst_sof",   64'(bus.word_sof),       64'd0);
      idle(2);
      chk("D_rst_eol", 64'(bus.word_eol),   64'd0);
      chk("D_rst_fd",  64'(bus.frame_done), 64'd0);
`ifdef EDGE_BIT_PACKER_COUNT_EN
      chk("D_rst_cnt", 64'(edge_count), 64'd0);
`endif
      rstN = 1'b0;
      idle(1);
      bus.word_out_ready = 1'b1;
      base = q.size(); fd_base = fd_cnt;
      for (int i = 0; i < W*H; i++) px((i == 3) ? 8'h80 : 8'h00);
`ifdef EDGE_BIT_PACKER_COUNT_EN
      chk("D_cnt", 64'(edge_count), 64'd1);
`endif
      idle(4);
      chk("D_nwords", 64'(q.size() - base), 64'd6);
      chk("D_w0", recv(base),     mk(32'h0000_0008, 1'b1, 1'b0));
      chk("D_w1", recv(base + 1), mk(32'h0000_0000, 1'b0, 1'b1));
      chk("D_w2", recv(base + 2), mk(32'h0000_0000, 1'b0, 1'b0));
      chk("D_fd_count", 64'(fd_cnt - fd_base), 64'd1);
      chk("D_ovf", 64'(bus.overflow), 64'd0);

      // Frame E: all zeros
      base = q.size(); fd_base = fd_cnt;
      for (int i = 0; i < W*H; i++) px(8'h00);
`ifdef EDGE_BIT_PACKER_COUNT_EN
      chk("E_cnt", 64'(edge_count), 64'd0);
`endif
      idle(4);
      chk("E_nwords", 64'(q.size() - base), 64'd6);
      chk("E_w0", recv(base),     mk(32'h0000_0000, 1'b1, 1'b0));
      chk("E_w5", recv(base + 5), mk(32'h0000_0000, 1'b0, 1'b1));
      chk("E_fd_count", 64'(fd_cnt - fd_base), 64'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
